muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit. Sits beside the ALU, directly downstream of the register file.
- Consumes the Rs1/Rs2 operand values read by the register file, plus the rd index.
- Produces a 32-bit result and rd index for the write-back MUX feeding the register file write port.
- Multi-cycle; uses valid/ready handshakes so the pipeline can stall around it.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/muldiv_unit_signfix.sv | 12 +
 rtl/muldiv_unit.sv | 171 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register index, RV32M op encodings and mul/div unit states.
`ifndef RISCV_PKG_SV
`define RISCV_PKG_SV

`define REG_SIZE 5

package riscv_pkg;

  typedef logic [`REG_SIZE-1:0] reg_idx_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } muldiv_state_e;

  localparam int unsigned MULDIV_ITERS = 32;

  // rs1 is treated as signed by MULH, MULHSU, DIV and REM
  function automatic logic op_signed_a(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed by MULH, DIV and REM
  function automatic logic op_signed_b(muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`endif

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negate: abs() of operands on latch, sign restore of results.
module muldiv_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// with sign correction in a final FIX step and a valid/ready handshake on both sides.
module muldiv_unit
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  reg_idx_t        rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output reg_idx_t        rd_out,
  output logic            busy
);

  localparam int unsigned     PW       = 2 * XLEN;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e    state;
  muldiv_op_e       op;
  reg_idx_t         rd_q;
  logic             a_neg;
  logic             b_neg;
  logic [XLEN-1:0]  opnd;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;

  muldiv_op_e      req_op;
  logic            req_a_neg;
  logic            req_b_neg;
  logic            req_div0;
  logic            req_ovf;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Request decode: operand signs and the two cases that bypass iteration
  always_comb begin
    req_op      = muldiv_op_e'(funct3);
    req_a_neg   = op_signed_a(req_op) & rs1_val[XLEN-1];
    req_b_neg   = op_signed_b(req_op) & rs2_val[XLEN-1];
    req_div0    = funct3[2] && (rs2_val == '0);
    req_ovf     = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                  (rs1_val == INT_MIN) && (rs2_val == '1);
    special_res = '0;
    if (req_div0) begin
      special_res = funct3[1] ? rs1_val : '1;
    end else begin
      special_res = funct3[1] ? '0 : rs1_val;
    end
  end

  muldiv_signfix #(.W(XLEN)) u_abs_a (.val(rs1_val), .neg(req_a_neg), .res(a_mag));
  muldiv_signfix #(.W(XLEN)) u_abs_b (.val(rs2_val), .neg(req_b_neg), .res(b_mag));

  // acc holds {product_hi, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   trial;
  logic            sub_ge;
  logic [XLEN-1:0] sub_diff;

  assign add_sum  = {1'b0, acc[PW-1:XLEN]} + {1'b0, opnd};
  assign trial    = acc[PW-1:XLEN-1];
  assign sub_ge   = (trial >= {1'b0, opnd});
  assign sub_diff = trial[XLEN-1:0] - opnd;

  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_res;

  muldiv_signfix #(.W(PW))   u_fix_prod (.val(acc),             .neg(a_neg ^ b_neg), .res(prod_fix));
  muldiv_signfix #(.W(XLEN)) u_fix_quo  (.val(acc[XLEN-1:0]),   .neg(a_neg ^ b_neg), .res(quo_fix));
  muldiv_signfix #(.W(XLEN)) u_fix_rem  (.val(acc[PW-1:XLEN]),  .neg(a_neg),         .res(rem_fix));

  always_comb begin
    fix_res = '0;
    case (op)
      OP_MUL:                        fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[PW-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res = quo_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  // Control FSM, iteration core and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op        <= OP_MUL;
      rd_q      <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op    <= req_op;
            rd_q  <= rd_in;
            a_neg <= req_a_neg;
            b_neg <= req_b_neg;
            cnt   <= '0;
            if (req_div0 || req_ovf) begin
              result <= special_res;
              rd_out <= rd_in;
              state  <= DONE;
            end else if (funct3[2]) begin
              opnd  <= b_mag;
              acc   <= {{XLEN{1'b0}}, a_mag};
              state <= DIV;
            end else begin
              opnd  <= a_mag;
              acc   <= {{XLEN{1'b0}}, b_mag};
              state <= MUL;
            end
          end
        end
        MUL: begin
          acc <= acc[0] ? {add_sum, acc[XLEN-1:1]} : {1'b0, acc[PW-1:1]};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        DIV: begin
          acc <= {(sub_ge ? sub_diff : trial[XLEN-1:0]), acc[XLEN-2:0], sub_ge};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          result <= fix_res;
          rd_out <= rd_q;
          state  <= DONE;
        end
        DONE: begin
          // out_valid lags DONE entry by one edge; handshake only counts once it is visible
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, randomized traffic with backpressure,
// a held-output window and an abort by reset mid-operation.
module tb_muldiv_unit;
  import riscv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  reg_idx_t    rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  reg_idx_t    rd_out;
  logic        busy;

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .funct3   (funct3),
    .rs1_val  (rs1_val),
    .rs2_val  (rs2_val),
    .rd_in    (rd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .rd_out   (rd_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    reg_idx_t    rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   hold_obs = 0;
  int   hold_req = 0;
  bit   rand_bp = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain 64-bit arithmetic following the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    longint          p;
    longint unsigned pu;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 0) ||
           (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input reg_idx_t rd);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    funct3   = op;
    rs1_val  = a;
    rs2_val  = b;
    rd_in    = rd;
    e.res = model(op, a, b);
    e.rd  = rd;
    e.acc = cyc + 1;
    e.lat = is_special(op, a, b) ? 1 : 34;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Garbage on the request bus while the unit is busy
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    rs1_val  = $urandom;
    rs2_val  = $urandom;
    rd_in    = reg_idx_t'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  // out_ready driver: random stalls, or a forced 10-cycle hold when requested
  initial begin
    int hold_ack;
    int hold_left;
    hold_ack  = 0;
    hold_left = 0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hold_req != hold_ack && out_valid) begin
        hold_ack  = hold_req;
        hold_left = 10;
      end
      if (hold_left > 0) begin
        out_ready = 1'b0;
        hold_left--;
      end else begin
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor: compares each presented result with the scoreboard head
  initial begin
    bit          pv;
    bit          hs_pending;
    logic [31:0] snap_res;
    reg_idx_t    snap_rd;
    exp_t        e;
    pv = 1'b0;
    hs_pending = 1'b0;
    snap_res = '0;
    snap_rd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pv = 1'b0;
        hs_pending = 1'b0;
        continue;
      end
      if (out_valid) begin
        if (!pv) begin
          if (q.size() == 0) begin
            check("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            e = q[0];
            check("latency", 32'(cyc - e.acc), 32'(e.lat));
            check("result", result, e.res);
            check("rd_out", 32'(rd_out), 32'(e.rd));
          end
          snap_res = result;
          snap_rd  = rd_out;
        end else begin
          check("held_result", result, snap_res);
          check("held_rd_out", 32'(rd_out), 32'(snap_rd));
        end
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        if (out_ready) begin
          if (q.size() != 0) void'(q.pop_front());
          hs_pending = 1'b1;
          pv = 1'b0;
        end else begin
          hold_obs++;
          pv = 1'b1;
        end
      end else begin
        if (hs_pending) begin
          check("in_ready_after_handshake", 32'(in_ready), 32'd1);
          hs_pending = 1'b0;
        end
        pv = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_before;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    funct3   = '0;
    rs1_val  = '0;
    rs2_val  = '0;
    rd_in    = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", 32'(rd_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Directed RV32M cases, including divide-by-zero and signed overflow
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd3);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
    issue(3'd5, 32'd100, 32'd7, 5'd6);
    issue(3'd7, 32'd100, 32'd7, 5'd7);
    issue(3'd5, 32'd13, 32'd0, 5'd8);
    issue(3'd7, 32'd13, 32'd0, 5'd10);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);
    issue(3'd0, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
    wait_drain();

    // Backpressure: 10 cycles of out_ready low in DONE
    hold_before = hold_obs;
    hold_req++;
    issue(3'd5, 32'd100, 32'd7, 5'd21);
    wait_drain();
    check("hold_cycles", 32'(hold_obs - hold_before), 32'd10);

    // Randomized traffic with random output stalls
    rand_bp = 1'b1;
    repeat (60) issue(3'($urandom), pick(), pick(), reg_idx_t'($urandom));
    wait_drain();
    rand_bp = 1'b0;

    // Reset during iteration 15 of a multiply
    issue(3'd0, 32'h0000_1234, 32'h0000_5678, 5'd17);
    repeat (14) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_rd_out", 32'(rd_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    check("post_rst_no_valid", 32'(out_valid), 32'd0);
    check("post_rst_idle", 32'(busy), 32'd0);
    issue(3'd0, 32'd3, 32'd5, 5'd11);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
